// File: rtl/uart_fifo_param.sv
// Parametrised first-word-fall-through FIFO for the UART TX/RX data paths.
// Provides occupancy flags, programmable thresholds, sticky error flags and a synchronous flush.
module uart_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic is_full;
    logic is_empty;
    logic eff_push;
    logic eff_pop;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign eff_push = push & (~is_full | pop);
    assign eff_pop  = pop & ~is_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (eff_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (eff_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({eff_push, eff_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push && !eff_push) begin
                overflow_d = 1'b1;
            end
            if (pop && is_empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (eff_push && !clr) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = is_empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_empty   = is_empty;
    assign fifo_full    = is_full;
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: doc/uart_fifo_param.md
Name: uart_fifo_param

Overview:
- Parametrised synchronous FIFO for the UART TX/RX data paths. Successor to the fixed 16x8 TX FIFO.
- Configurable data width and depth.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush.
- Sits between the bus-side register interface and the UART shift engine. Read data is first-word-fall-through.

Parameters:
- DATA_WIDTH, 8: width of each entry in bits (1..32).
- DEPTH, 16: number of entries. Power of two, 2..256.
- AF_LEVEL, 12: almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- Derived: AW = log2(DEPTH) (pointer width); CW = AW+1 (count width).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- clr, input, 1: synchronous flush. Empties the FIFO and clears sticky errors.
- push, input, 1: write request for data_in.
- pop, input, 1: read request. Consumes the entry presented on data_out.
- data_in, input, DATA_WIDTH: write data.
- data_out, output, DATA_WIDTH: head-of-FIFO data (FWFT).
- fifo_empty, output, 1: count == 0.
- fifo_full, output, 1: count == DEPTH.
- almost_empty, output, 1: count <= AE_LEVEL.
- almost_full, output, 1: count >= AF_LEVEL.
- count, output, CW: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky. Set by a push that was dropped.
- underflow, output, 1: sticky. Set by a pop that was ignored.

Behaviour:
- Reset (rst high, asynchronous):
  - wr_ptr, rd_ptr and count are 0; overflow and underflow are 0.
  - Outputs: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, data_out=0.
  - Memory contents are not reset.
  - A reset mid-operation discards all entries immediately.
- State is held in registers: wr_ptr (AW bits), rd_ptr (AW bits), count (CW bits), overflow, underflow, and a DEPTH x DATA_WIDTH storage array. Pointers wrap modulo DEPTH naturally.
- Flags are combinational decodes of the registered count. They reflect an operation on the cycle after the clock edge that applied it.
- data_out = mem[rd_ptr] when count != 0, else 0. Zero read latency: an entry pushed at edge N appears on data_out after edge N if the FIFO was empty.
- Per-edge actions (clr low), with eff_push = push & (~full | pop) and eff_pop = pop & ~empty:
  - push only, not full: write mem[wr_ptr], wr_ptr+1, count+1.
  - push only, full: write dropped, no state change, overflow <= 1.
  - pop only, not empty: rd_ptr+1, count-1.
  - pop only, empty: ignored, underflow <= 1.
  - push and pop, 0 < count < DEPTH: write and read both occur, count unchanged.
  - push and pop, full: both occur (the read frees the slot), count stays DEPTH, no overflow.
  - push and pop, empty: write occurs, pop ignored, count becomes 1, underflow <= 1. The pushed word is not consumed.
- Arithmetic: count never exceeds DEPTH and never goes below 0. Pointer increments wrap from DEPTH-1 to 0.
- clr (synchronous, higher priority than push/pop): at the edge, wr_ptr=rd_ptr=count=0 and overflow=underflow=0. Same-cycle push/pop are discarded and set no error flags.
- Sticky errors stay set until clr or rst. Each is a level, not a pulse.
- No combinational path from push/pop to any output.

Test Plan (DATA_WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=2):
- Reset, then idle -> fifo_empty=1, almost_empty=1, count=0, data_out=0, overflow=underflow=0.
- Push 0x01..0x10 on 16 consecutive cycles:
  - almost_empty deasserts after the 3rd push; almost_full asserts after the 12th; fifo_full=1 and count=16 after the 16th.
  - A 17th push of 0xAA sets overflow=1 with count=16 unchanged.
  - 16 pops then return 0x01..0x10 in order, never 0xAA.
- Wrap-around: push 10, pop 10, then push 0x20..0x2B (12 words) -> wr_ptr wraps past 15. Pops return 0x20..0x2B in order, count returns to 0.
- Simultaneous push/pop:
  - At count=16, push 0x55 + pop -> count stays 16, no overflow, 0x55 read last.
  - At count=0, push 0x66 + pop -> count=1, underflow=1, data_out=0x66.
- Pop on empty -> underflow=1 and stays 1 across 5 idle cycles. clr -> underflow=0, count=0.
- Flush and reset mid-stream:
  - With count=7, assert clr together with push -> next cycle count=0, fifo_empty=1, pushed word discarded.
  - Refill to 5, assert rst asynchronously between edges -> flags return to reset values immediately.
